// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the cache-facing memory controller
package mem_ctrl_pkg;

    localparam int MEM_CTRL_LATENCY = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [DATA_W-1:0] block_data_t;

    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_ctrl_state_t;
    typedef enum logic {REQ_ICACHE = 1'b0, REQ_DCACHE = 1'b1} requestor_t;

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - pending icache slot plus fixed-priority pick between icache and dcache
module mem_ctrl_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              idle,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              grant_valid,
    output logic              grant_is_dcache,
    output logic              grant_is_write,
    output logic [ADDR_W-1:0] grant_addr,
    output logic [DATA_W-1:0] grant_data
);

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    always_comb begin
        pend_valid_d     = pend_valid_q;
        pend_addr_d      = pend_addr_q;
        icache_req_ready = ~pend_valid_q;
        dcache_req_ready = idle & ~pend_valid_q & ~icache_req_valid;
        grant_valid      = 1'b0;
        grant_is_dcache  = 1'b0;
        grant_is_write   = 1'b0;
        grant_addr       = pend_addr_q;
        grant_data       = '0;
        if (idle) begin
            if (pend_valid_q) begin
                grant_valid  = 1'b1;
                pend_valid_d = 1'b0;
            end else if (icache_req_valid) begin
                grant_valid = 1'b1;
                grant_addr  = icache_req_block_addr;
            end else if (dcache_req_valid) begin
                grant_valid     = 1'b1;
                grant_is_dcache = 1'b1;
                grant_is_write  = (dcache_req_type == REQ_WRITE);
                grant_addr      = dcache_req_block_addr;
                grant_data      = dcache_req_block_data;
            end
        end else if (icache_req_valid && !pend_valid_q) begin
            // controller busy: park the icache request until the next IDLE
            pend_valid_d = 1'b1;
            pend_addr_d  = icache_req_block_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - serves icache/dcache block requests against main-memory SRAM with fixed latency
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LATENCY = MEM_CTRL_LATENCY
) (
    input  logic              clk,
    input  logic              rst_aH,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    output logic              icache_resp_valid,
    output logic [DATA_W-1:0] icache_resp_block_data,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              dcache_resp_valid,
    output logic [DATA_W-1:0] dcache_resp_block_data,
    output logic              main_mem_csb0,
    output logic              main_mem_web0,
    output logic [ADDR_W-1:0] main_mem_addr0,
    output logic [DATA_W-1:0] main_mem_din0,
    input  logic [DATA_W-1:0] main_mem_dout0
);

    localparam logic [7:0] CNT_LAST = 8'((LATENCY > 2) ? (LATENCY - 3) : 0);

    mem_ctrl_state_t   state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    requestor_t        owner_q, owner_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              csb_q, csb_d, web_q, web_d;
    logic              iresp_q, iresp_d, dresp_q, dresp_d;

    logic              grant_valid, grant_is_dcache, grant_is_write;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    mem_ctrl_arbiter u_arbiter (
        .clk                   (clk),
        .rst                   (rst_aH),
        .idle                  (state_q == IDLE),
        .icache_req_valid      (icache_req_valid),
        .icache_req_block_addr (icache_req_block_addr),
        .icache_req_ready      (icache_req_ready),
        .dcache_req_valid      (dcache_req_valid),
        .dcache_req_type       (dcache_req_type),
        .dcache_req_block_addr (dcache_req_block_addr),
        .dcache_req_block_data (dcache_req_block_data),
        .dcache_req_ready      (dcache_req_ready),
        .grant_valid           (grant_valid),
        .grant_is_dcache       (grant_is_dcache),
        .grant_is_write        (grant_is_write),
        .grant_addr            (grant_addr),
        .grant_data            (grant_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        iresp_d    = 1'b0;
        dresp_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d    = grant_is_dcache ? REQ_DCACHE : REQ_ICACHE;
                    is_write_d = grant_is_write;
                    addr_d     = grant_addr;
                    data_d     = grant_data;
                    cnt_d      = '0;
                    if (LATENCY == 2) begin
                        state_d = ACCESS;
                        csb_d   = 1'b0;
                        web_d   = ~grant_is_write;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ACCESS;
                    csb_d   = 1'b0;
                    web_d   = ~is_write_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                iresp_d = (owner_q == REQ_ICACHE);
                dresp_d = (owner_q == REQ_DCACHE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= REQ_ICACHE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            iresp_q    <= 1'b0;
            dresp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            iresp_q    <= iresp_d;
            dresp_q    <= dresp_d;
        end
    end

    // SRAM read data arrives the cycle after the strobe, which is exactly the RESP cycle
    assign icache_resp_valid      = iresp_q;
    assign icache_resp_block_data = iresp_q ? main_mem_dout0 : '0;
    assign dcache_resp_valid      = dresp_q;
    assign dcache_resp_block_data = dresp_q ? (is_write_q ? data_q : main_mem_dout0) : '0;
    assign main_mem_csb0          = csb_q;
    assign main_mem_web0          = web_q;
    assign main_mem_addr0         = addr_q;
    assign main_mem_din0          = data_q;

    a_latency_legal: assert property (@(posedge clk) LATENCY >= 2);
    a_icache_no_overrun: assert property (@(posedge clk) disable iff (rst_aH)
        !(icache_req_valid && !icache_req_ready));
    a_single_resp: assert property (@(posedge clk) disable iff (rst_aH)
        !(icache_resp_valid && dcache_resp_valid));

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl at LATENCY=4 and LATENCY=2
module tb_mem_ctrl;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    exp_t q_i[$];
    exp_t q_d[$];
    exp_t q_m[$];
    exp_t q_d2[$];

    logic        ivalid, iready, iresp_valid;
    logic [7:0]  iaddr;
    logic [63:0] iresp_data;
    logic        dvalid, dtype, dready, dresp_valid;
    logic [7:0]  daddr;
    logic [63:0] ddata, dresp_data;
    logic        csb0, web0;
    logic [7:0]  maddr;
    logic [63:0] mdin, mdout;
    logic [63:0] mem [0:255];

    logic        d2valid, d2ready, d2resp_valid;
    logic [7:0]  d2addr;
    logic [63:0] d2resp_data;
    logic        i2ready, i2resp_valid;
    logic [63:0] i2resp_data;
    logic        csb2, web2;
    logic [7:0]  maddr2;
    logic [63:0] mdin2, mdout2;
    logic [63:0] mem2 [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl #(.LATENCY(4)) u_dut (
        .clk(clk), .rst_aH(rst),
        .icache_req_valid(ivalid), .icache_req_block_addr(iaddr), .icache_req_ready(iready),
        .icache_resp_valid(iresp_valid), .icache_resp_block_data(iresp_data),
        .dcache_req_valid(dvalid), .dcache_req_type(dtype), .dcache_req_block_addr(daddr),
        .dcache_req_block_data(ddata), .dcache_req_ready(dready),
        .dcache_resp_valid(dresp_valid), .dcache_resp_block_data(dresp_data),
        .main_mem_csb0(csb0), .main_mem_web0(web0), .main_mem_addr0(maddr),
        .main_mem_din0(mdin), .main_mem_dout0(mdout)
    );

    mem_ctrl #(.LATENCY(2)) u_dut2 (
        .clk(clk), .rst_aH(rst),
        .icache_req_valid(1'b0), .icache_req_block_addr(8'h00), .icache_req_ready(i2ready),
        .icache_resp_valid(i2resp_valid), .icache_resp_block_data(i2resp_data),
        .dcache_req_valid(d2valid), .dcache_req_type(1'b0), .dcache_req_block_addr(d2addr),
        .dcache_req_block_data(64'h0), .dcache_req_ready(d2ready),
        .dcache_resp_valid(d2resp_valid), .dcache_resp_block_data(d2resp_data),
        .main_mem_csb0(csb2), .main_mem_web0(web2), .main_mem_addr0(maddr2),
        .main_mem_din0(mdin2), .main_mem_dout0(mdout2)
    );

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) mem[maddr] <= mdin;
            else       mdout <= mem[maddr];
        end
        if (!csb2 && web2) mdout2 <= mem2[maddr2];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for ready while holding the request; returns the accepting cycle or -1
    task automatic wait_accept(input bit second, output int acc);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((second ? d2ready : dready) === 1'b1) begin
                acc = cyc;
                tick();
                break;
            end
            tick();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (iresp_valid) begin
                if (q_i.size() == 0) check("icache_resp_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else begin
                    e = q_i.pop_front();
                    check("icache_resp_cycle", 64'(cyc), 64'(e.cyc));
                    check("icache_resp_data", iresp_data, e.val);
                end
            end else check("icache_data_idle_zero", iresp_data, 64'h0);
            if (dresp_valid) begin
                if (q_d.size() == 0) check("dcache_resp_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else begin
                    e = q_d.pop_front();
                    check("dcache_resp_cycle", 64'(cyc), 64'(e.cyc));
                    check("dcache_resp_data", dresp_data, e.val);
                end
            end else check("dcache_data_idle_zero", dresp_data, 64'h0);
            if (!csb0) begin
                if (q_m.size() == 0) check("mem_strobe_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else begin
                    e = q_m.pop_front();
                    check("mem_strobe_cycle", 64'(cyc), 64'(e.cyc));
                    check("mem_strobe_web_addr", 64'({web0, maddr}), e.val);
                end
            end
            if (d2resp_valid) begin
                if (q_d2.size() == 0) check("l2_resp_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else begin
                    e = q_d2.pop_front();
                    check("l2_resp_cycle", 64'(cyc), 64'(e.cyc));
                    check("l2_resp_data", d2resp_data, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, acc;
        for (int a = 0; a < 256; a++) begin
            mem[a]  = 64'h0;
            mem2[a] = 64'h0;
        end
        mem[8'h10]  = 64'hA5A5_0000_1111_2222;
        mem2[8'h10] = 64'hA5A5_0000_1111_2222;
        mem2[8'h11] = 64'h0123_4567_89AB_CDEF;
        ivalid = 0; iaddr = 0; dvalid = 0; dtype = 0; daddr = 0; ddata = 0;
        d2valid = 0; d2addr = 0;

        tick(); tick();
        check("rst_icache_resp_valid", 64'(iresp_valid), 64'h0);
        check("rst_dcache_resp_valid", 64'(dresp_valid), 64'h0);
        check("rst_csb0", 64'(csb0), 64'h1);
        check("rst_web0", 64'(web0), 64'h1);
        check("rst_resp_data", iresp_data | dresp_data, 64'h0);
        check("rst_icache_ready", 64'(iready), 64'h1);
        rst = 0;
        tick();

        // icache read of preloaded block
        t = cyc; ivalid = 1; iaddr = 8'h10;
        q_m.push_back('{t + 3, 64'({1'b1, 8'h10})});
        q_i.push_back('{t + 4, 64'hA5A5_0000_1111_2222});
        tick(); ivalid = 0;
        repeat (6) tick();

        // dcache write-through then icache read-back
        t = cyc; dvalid = 1; dtype = 1; daddr = 8'h20; ddata = 64'hDEAD_BEEF;
        q_m.push_back('{t + 3, 64'({1'b0, 8'h20})});
        q_d.push_back('{t + 4, 64'hDEAD_BEEF});
        tick(); dvalid = 0; dtype = 0; ddata = 0;
        repeat (6) tick();
        t = cyc; ivalid = 1; iaddr = 8'h20;
        q_m.push_back('{t + 3, 64'({1'b1, 8'h20})});
        q_i.push_back('{t + 4, 64'hDEAD_BEEF});
        tick(); ivalid = 0;
        repeat (6) tick();

        // simultaneous icache and dcache in IDLE
        t = cyc; ivalid = 1; iaddr = 8'h10; dvalid = 1; dtype = 0; daddr = 8'h20;
        q_m.push_back('{t + 3, 64'({1'b1, 8'h10})});
        q_i.push_back('{t + 4, 64'hA5A5_0000_1111_2222});
        q_m.push_back('{t + 8, 64'({1'b1, 8'h20})});
        q_d.push_back('{t + 9, 64'hDEAD_BEEF});
        @(negedge clk);
        check("dcache_ready_when_icache_wins", 64'(dready), 64'h0);
        tick(); ivalid = 0;
        wait_accept(1'b0, acc);
        check("dcache_accept_cycle", 64'(acc), 64'(t + 5));
        dvalid = 0;
        repeat (6) tick();

        // icache arrives mid-dcache operation and parks in the pending slot
        t = cyc; dvalid = 1; dtype = 0; daddr = 8'h10;
        q_m.push_back('{t + 3, 64'({1'b1, 8'h10})});
        q_d.push_back('{t + 4, 64'hA5A5_0000_1111_2222});
        q_m.push_back('{t + 8, 64'({1'b1, 8'h20})});
        q_i.push_back('{t + 9, 64'hDEAD_BEEF});
        tick(); dvalid = 0;
        tick(); ivalid = 1; iaddr = 8'h20;
        @(negedge clk);
        check("icache_ready_while_busy", 64'(iready), 64'h1);
        tick(); ivalid = 0;
        @(negedge clk);
        check("icache_ready_pending_full", 64'(iready), 64'h0);
        repeat (8) tick();

        // reset mid-read drops the transaction
        t = cyc; ivalid = 1; iaddr = 8'h10;
        tick(); ivalid = 0;
        tick();
        check("busy_dcache_ready", 64'(dready), 64'h0);
        #2 rst = 1;
        #1;
        check("midrst_icache_resp_valid", 64'(iresp_valid), 64'h0);
        check("midrst_csb0", 64'(csb0), 64'h1);
        check("midrst_web0", 64'(web0), 64'h1);
        check("midrst_dcache_ready", 64'(dready), 64'h1);
        tick(); tick();
        rst = 0;
        repeat (2) tick();
        t = cyc; ivalid = 1; iaddr = 8'h20;
        q_m.push_back('{t + 3, 64'({1'b1, 8'h20})});
        q_i.push_back('{t + 4, 64'hDEAD_BEEF});
        tick(); ivalid = 0;
        repeat (6) tick();

        // LATENCY=2 instance: back-to-back dcache reads
        t = cyc; d2valid = 1; d2addr = 8'h10;
        q_d2.push_back('{t + 2, 64'hA5A5_0000_1111_2222});
        q_d2.push_back('{t + 5, 64'h0123_4567_89AB_CDEF});
        @(negedge clk);
        check("l2_first_ready", 64'(d2ready), 64'h1);
        tick(); d2addr = 8'h11;
        wait_accept(1'b1, acc);
        check("l2_second_accept_cycle", 64'(acc), 64'(t + 3));
        d2valid = 0;
        repeat (5) tick();

        check("icache_queue_drained", 64'(q_i.size()), 64'h0);
        check("dcache_queue_drained", 64'(q_d.size()), 64'h0);
        check("mem_queue_drained", 64'(q_m.size()), 64'h0);
        check("l2_queue_drained", 64'(q_d2.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
